// File: rtl/risc_pkg.sv
// Shared definitions for the 5-stage core: datapath defaults, ALU operation
// encodings, the memory-sequencer state encoding and the EX/MEM control bundle.
package risc_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  // Legacy-compatible numeric state codes; the enum below reuses them so
  // waveform viewers and older scripts decode the same values.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    WAIT   = ST_WAIT
  } mem_state_e;

  // Control bits carried from EX into the EX/MEM slot.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Up-counter of stalled memory cycles with synchronous clear, count enable
// and a terminal-count flag at MAX_WAIT-1. Saturates at terminal count.
module mem_wait_timer #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int            CW     = $clog2(MAX_WAIT);
  localparam logic [CW-1:0] TC_VAL = CW'(MAX_WAIT - 1);

  logic [CW-1:0] count;

  // Count stalled cycles; clear wins so a new transaction always starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TC_VAL)) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline slot, data-memory access sequencer and MEM/WB register.
// Also produces the EX-stage forwarding selects and the load-use flag.
//
// state  | meaning
// IDLE   | slot holds no memory operation
// ACCESS | first request cycle of the memory operation in the slot
// WAIT   | request still outstanding, counting stalled cycles toward timeout
module ex_mem_stage #(
  parameter int DATA_W     = risc_pkg::DEF_DATA_W,
  parameter int REG_ADDR_W = risc_pkg::DEF_REG_ADDR_W,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     ALU_Result,
  input  logic [DATA_W-1:0]     RD2_2,
  input  logic                  ID_EX_Valid,
  input  logic                  ID_EX_RegWrite,
  input  logic                  ID_EX_MR,
  input  logic                  ID_EX_MW,
  input  logic                  ID_EX_MemToReg,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rd,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rs,
  input  logic [REG_ADDR_W-1:0] ID_EX_Rt,
  output logic [DATA_W-1:0]     ALU_Result_1,
  output logic                  FA,
  output logic                  FB,
  output logic                  Load_Use,
  output logic                  Mem_Stall,
  output logic                  DM_Req,
  output logic                  DM_We,
  output logic [DATA_W-1:0]     DM_Addr,
  output logic [DATA_W-1:0]     DM_WData,
  input  logic                  DM_Ready,
  input  logic [DATA_W-1:0]     DM_RData,
  output logic                  MEM_WB_Valid,
  output logic                  MEM_WB_RegWrite,
  output logic [REG_ADDR_W-1:0] MEM_WB_Rd,
  output logic [DATA_W-1:0]     MEM_WB_Data,
  output logic                  Mem_Err
);

  import risc_pkg::*;

  ctrl_t                 slot_ctrl;
  logic [REG_ADDR_W-1:0] slot_rd;
  logic [DATA_W-1:0]     slot_wdata;

  mem_state_e            state;
  mem_state_e            state_nxt;

  logic                  mem_op;
  logic                  in_mem_op;
  logic                  is_load;
  logic                  wait_tc;
  logic                  timeout;
  logic [DATA_W-1:0]     wb_data;

  // Register 0 is hardwired, so it never participates in forwarding or hazards.
  function automatic logic rd_match(input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] src);
    return (rd != '0) && (rd == src);
  endfunction

  assign mem_op    = slot_ctrl.valid & (slot_ctrl.mem_read | slot_ctrl.mem_write);
  assign in_mem_op = ID_EX_Valid & (ID_EX_MR | ID_EX_MW);

  // An illegal read+write is treated as a store, so it never returns load data.
  assign is_load   = slot_ctrl.mem_read & ~slot_ctrl.mem_write;

  // Timeout takes the place of DM_Ready on the last permitted cycle.
  assign timeout   = (state == WAIT) & wait_tc & ~DM_Ready;
  assign Mem_Stall = mem_op & ~DM_Ready & ~timeout;

  assign DM_Req    = mem_op & ~timeout;
  assign DM_We     = DM_Req & slot_ctrl.mem_write;
  assign DM_Addr   = ALU_Result_1;
  assign DM_WData  = slot_wdata;

  assign FA        = slot_ctrl.valid & slot_ctrl.reg_write & ~slot_ctrl.mem_read
                   & rd_match(slot_rd, ID_EX_Rs);
  assign FB        = slot_ctrl.valid & slot_ctrl.reg_write & ~slot_ctrl.mem_read
                   & rd_match(slot_rd, ID_EX_Rt);
  assign Load_Use  = slot_ctrl.valid & slot_ctrl.mem_read & slot_ctrl.reg_write
                   & (rd_match(slot_rd, ID_EX_Rs) | rd_match(slot_rd, ID_EX_Rt));

  // Writeback value: memory data for loads (zeroed on timeout), else ALU result.
  always_comb begin
    wb_data = ALU_Result_1;
    if (is_load && slot_ctrl.mem_to_reg) begin
      wb_data = timeout ? '0 : DM_RData;
    end
  end

  // Stalled cycles stay in WAIT; otherwise the incoming slot content decides.
  always_comb begin
    state_nxt = state;
    if (Mem_Stall) begin
      state_nxt = WAIT;
    end else if (in_mem_op) begin
      state_nxt = ACCESS;
    end else begin
      state_nxt = IDLE;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // EX/MEM slot: advances on every unstalled edge, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_ctrl    <= '0;
      slot_rd      <= '0;
      ALU_Result_1 <= '0;
      slot_wdata   <= '0;
    end else if (!Mem_Stall) begin
      slot_ctrl.valid      <= ID_EX_Valid;
      slot_ctrl.reg_write  <= ID_EX_RegWrite;
      slot_ctrl.mem_read   <= ID_EX_MR;
      slot_ctrl.mem_write  <= ID_EX_MW;
      slot_ctrl.mem_to_reg <= ID_EX_MemToReg;
      slot_rd              <= ID_EX_Rd;
      ALU_Result_1         <= ALU_Result;
      slot_wdata           <= RD2_2;
    end
  end

  // MEM/WB register: captures the slot result whenever the slot completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_WB_Valid    <= 1'b0;
      MEM_WB_RegWrite <= 1'b0;
      MEM_WB_Rd       <= '0;
      MEM_WB_Data     <= '0;
    end else if (!Mem_Stall) begin
      MEM_WB_Valid    <= slot_ctrl.valid;
      MEM_WB_RegWrite <= slot_ctrl.valid & slot_ctrl.reg_write;
      MEM_WB_Rd       <= slot_rd;
      MEM_WB_Data     <= wb_data;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Mem_Err <= 1'b0;
    end else if (timeout) begin
      Mem_Err <= 1'b1;
    end
  end

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (~Mem_Stall),
    .enable (Mem_Stall),
    .tc     (wait_tc)
  );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: per-scenario tasks with inline checks,
// plus a writeback scoreboard fed when instructions are driven into EX.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ALU_Result, RD2_2, DM_RData;
  logic        ID_EX_Valid, ID_EX_RegWrite, ID_EX_MR, ID_EX_MW, ID_EX_MemToReg;
  logic [3:0]  ID_EX_Rd, ID_EX_Rs, ID_EX_Rt;
  logic [31:0] ALU_Result_1, DM_Addr, DM_WData, MEM_WB_Data;
  logic        FA, FB, Load_Use, Mem_Stall, DM_Req, DM_We, DM_Ready;
  logic        MEM_WB_Valid, MEM_WB_RegWrite, Mem_Err;
  logic [3:0]  MEM_WB_Rd;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  rd;
    logic        rw;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  wb_exp_t mon_e;
  logic    adv_q = 1'b0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(4), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .ALU_Result(ALU_Result), .RD2_2(RD2_2),
    .ID_EX_Valid(ID_EX_Valid), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MR(ID_EX_MR),
    .ID_EX_MW(ID_EX_MW), .ID_EX_MemToReg(ID_EX_MemToReg), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ALU_Result_1(ALU_Result_1),
    .FA(FA), .FB(FB), .Load_Use(Load_Use), .Mem_Stall(Mem_Stall), .DM_Req(DM_Req),
    .DM_We(DM_We), .DM_Addr(DM_Addr), .DM_WData(DM_WData), .DM_Ready(DM_Ready),
    .DM_RData(DM_RData), .MEM_WB_Valid(MEM_WB_Valid), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_Data(MEM_WB_Data), .Mem_Err(Mem_Err)
  );

  // Remember whether the last edge let the slot advance into MEM/WB.
  always @(posedge clk) adv_q <= (Mem_Stall === 1'b0);

  // Scoreboard: each writeback produced by an advancing edge is compared in order.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && adv_q && MEM_WB_Valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", MEM_WB_Rd, MEM_WB_Data);
      end else begin
        mon_e = exp_q.pop_front();
        if (MEM_WB_Rd !== mon_e.rd || MEM_WB_RegWrite !== mon_e.rw || MEM_WB_Data !== mon_e.data) begin
          failures++;
          $display("FAIL wb_bundle: got rd=%0d rw=%0b data=%h, required rd=%0d rw=%0b data=%h",
                   MEM_WB_Rd, MEM_WB_RegWrite, MEM_WB_Data, mon_e.rd, mon_e.rw, mon_e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one EX instruction and push its expected writeback if valid.
  task automatic drive_ex(input logic v, input logic rw, input logic mr, input logic mw,
                          input logic m2r, input logic [3:0] rd, input logic [3:0] rs,
                          input logic [3:0] rt, input logic [31:0] res, input logic [31:0] st,
                          input logic [31:0] ld);
    wb_exp_t e;
    ID_EX_Valid = v; ID_EX_RegWrite = rw; ID_EX_MR = mr; ID_EX_MW = mw; ID_EX_MemToReg = m2r;
    ID_EX_Rd = rd; ID_EX_Rs = rs; ID_EX_Rt = rt; ALU_Result = res; RD2_2 = st;
    if (v) begin
      e.rd = rd; e.rw = rw;
      e.data = (mr && !mw && m2r) ? ld : res;
      exp_q.push_back(e);
    end
  endtask

  task automatic bubble();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; DM_Ready = 1'b0; DM_RData = 32'h0;
    bubble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ALU_Result_1, FA, FB, Load_Use, Mem_Stall, DM_Req, DM_We, MEM_WB_Valid, MEM_WB_Data, Mem_Err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got res=%h req=%0b stall=%0b wbv=%0b err=%0b, required all 0",
               ALU_Result_1, DM_Req, Mem_Stall, MEM_WB_Valid, Mem_Err);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_forwarding();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 32'h1111_2222, 32'h0, 32'h0);
    cyc();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd5, 32'h0000_AAAA, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (FA !== 1'b1) begin failures++; $display("FAIL fwd_fa: got %0b required 1", FA); end
    checks++; if (FB !== 1'b0) begin failures++; $display("FAIL fwd_fb: got %0b required 0", FB); end
    checks++; if (ALU_Result_1 !== 32'h1111_2222) begin failures++; $display("FAIL fwd_value: got %h required 11112222", ALU_Result_1); end
    cyc();
    bubble();
    @(negedge clk);
    checks++; if ({FA, FB} !== 2'b00) begin failures++; $display("FAIL fwd_rd0: got FA=%0b FB=%0b required 0 0", FA, FB); end
    checks++; if (ALU_Result_1 !== 32'h0000_AAAA) begin failures++; $display("FAIL fwd_next_value: got %h required 0000aaaa", ALU_Result_1); end
    cyc(); cyc();
  endtask

  task automatic test_load_hit();
    drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 4'd0, 4'd0, 32'h40, 32'h0, 32'hDEAD_BEEF);
    cyc();
    bubble(); DM_Ready = 1'b1; DM_RData = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if ({DM_Req, DM_We} !== 2'b10) begin failures++; $display("FAIL hit_req: got req=%0b we=%0b required 1 0", DM_Req, DM_We); end
    checks++; if (DM_Addr !== 32'h40) begin failures++; $display("FAIL hit_addr: got %h required 00000040", DM_Addr); end
    checks++; if (Mem_Stall !== 1'b0) begin failures++; $display("FAIL hit_stall: got %0b required 0", Mem_Stall); end
    cyc();
    DM_Ready = 1'b0; DM_RData = 32'h0;
    @(negedge clk);
    checks++; if (DM_Req !== 1'b0) begin failures++; $display("FAIL hit_req_drop: got %0b required 0", DM_Req); end
    cyc();
  endtask

  task automatic test_store_wait();
    int stalls;
    stalls = 0;
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd0, 4'd0, 32'h10, 32'h1234, 32'h0);
    cyc();
    bubble();
    for (int k = 0; k < 4; k++) begin
      DM_Ready = (k == 3);
      @(negedge clk);
      if (Mem_Stall === 1'b1) stalls++;
      checks++;
      if ({DM_Req, DM_We} !== 2'b11 || DM_Addr !== 32'h10 || DM_WData !== 32'h1234) begin
        failures++;
        $display("FAIL store_stable: cycle %0d got req=%0b we=%0b addr=%h wdata=%h, required 1 1 00000010 00001234",
                 k, DM_Req, DM_We, DM_Addr, DM_WData);
      end
      cyc();
    end
    DM_Ready = 1'b0;
    checks++; if (stalls != 3) begin failures++; $display("FAIL store_stall_count: got %0d required 3", stalls); end
    cyc();
  endtask

  task automatic test_load_use();
    drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 4'd0, 4'd0, 32'h44, 32'h0, 32'h99);
    cyc();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 4'd4, 32'h22, 32'h0, 32'h0);
    DM_Ready = 1'b1; DM_RData = 32'h99;
    @(negedge clk);
    checks++; if (Load_Use !== 1'b1) begin failures++; $display("FAIL lu_flag: got %0b required 1", Load_Use); end
    checks++; if ({FA, FB} !== 2'b00) begin failures++; $display("FAIL lu_no_fwd: got FA=%0b FB=%0b required 0 0", FA, FB); end
    cyc();
    DM_Ready = 1'b0; DM_RData = 32'h0;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 4'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if ({Load_Use, FA} !== 2'b01) begin failures++; $display("FAIL lu_after: got LU=%0b FA=%0b required 0 1", Load_Use, FA); end
    bubble();
    cyc(); cyc();
  endtask

  task automatic test_back_to_back();
    drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 32'h100, 32'h0, 32'hA1);
    cyc();
    drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 32'h104, 32'h0, 32'hB2);
    DM_Ready = 1'b0;
    @(negedge clk);
    checks++; if (Mem_Stall !== 1'b1 || DM_Addr !== 32'h100) begin failures++; $display("FAIL b2b_wait: got stall=%0b addr=%h required 1 00000100", Mem_Stall, DM_Addr); end
    cyc();
    DM_Ready = 1'b1; DM_RData = 32'hA1;
    @(negedge clk);
    checks++; if (Mem_Stall !== 1'b0 || DM_Req !== 1'b1 || DM_Addr !== 32'h100) begin failures++; $display("FAIL b2b_first_done: got stall=%0b req=%0b addr=%h", Mem_Stall, DM_Req, DM_Addr); end
    cyc();
    bubble(); DM_Ready = 1'b1; DM_RData = 32'hB2;
    @(negedge clk);
    checks++; if (DM_Req !== 1'b1 || DM_Addr !== 32'h104 || Mem_Stall !== 1'b0) begin failures++; $display("FAIL b2b_no_gap: got req=%0b addr=%h stall=%0b required 1 00000104 0", DM_Req, DM_Addr, Mem_Stall); end
    cyc();
    DM_Ready = 1'b0; DM_RData = 32'h0;
    @(negedge clk);
    checks++; if (DM_Req !== 1'b0) begin failures++; $display("FAIL b2b_idle: got req=%0b required 0", DM_Req); end
    cyc();
  endtask

  task automatic test_random_alu();
    logic       pv, prw, rw;
    logic [3:0] prd, rd, rs, rt;
    logic [31:0] res;
    logic       efa, efb;
    pv = 1'b0; prw = 1'b0; prd = 4'd0;
    for (int i = 0; i < 16; i++) begin
      rw = 1'($urandom_range(0, 1)); rd = 4'($urandom_range(0, 15));
      rs = 4'($urandom_range(0, 15)); rt = 4'($urandom_range(0, 15)); res = $urandom;
      if (i % 3 == 0) rs = prd;
      drive_ex(1'b1, rw, 1'b0, 1'b0, 1'b0, rd, rs, rt, res, 32'h0, 32'h0);
      efa = pv && prw && prd != 4'd0 && prd == rs;
      efb = pv && prw && prd != 4'd0 && prd == rt;
      @(negedge clk);
      checks++;
      if (FA !== efa || FB !== efb || Mem_Stall !== 1'b0) begin
        failures++;
        $display("FAIL rand_fwd: step %0d got FA=%0b FB=%0b stall=%0b required %0b %0b 0", i, FA, FB, Mem_Stall, efa, efb);
      end
      cyc();
      pv = 1'b1; prw = rw; prd = rd;
    end
    bubble();
    cyc(); cyc();
  endtask

  task automatic test_timeout();
    int stalls;
    bit done;
    stalls = 0; done = 1'b0;
    checks++; if (Mem_Err !== 1'b0) begin failures++; $display("FAIL err_before: got %0b required 0", Mem_Err); end
    drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 4'd0, 4'd0, 32'h80, 32'h0, 32'h0);
    cyc();
    bubble(); DM_Ready = 1'b0; DM_RData = 32'hFFFF_FFFF;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (Mem_Stall === 1'b1) stalls++;
      else begin
        done = 1'b1;
        checks++; if (DM_Req !== 1'b0) begin failures++; $display("FAIL timeout_req: got %0b required 0", DM_Req); end
      end
      cyc();
    end
    checks++; if (!done) begin failures++; $display("FAIL timeout_bound: stall still %0b after 20 cycles, required release", Mem_Stall); end
    checks++; if (stalls != 7) begin failures++; $display("FAIL timeout_stalls: got %0d required 7", stalls); end
    DM_RData = 32'h0;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 4'd0, 4'd0, 32'h808, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (Mem_Err !== 1'b1) begin failures++; $display("FAIL timeout_err: got %0b required 1", Mem_Err); end
    cyc();
    bubble();
    @(negedge clk);
    checks++; if (Mem_Stall !== 1'b0 || Mem_Err !== 1'b1) begin failures++; $display("FAIL timeout_resume: got stall=%0b err=%0b required 0 1", Mem_Stall, Mem_Err); end
    cyc(); cyc();
  endtask

  task automatic test_reset_wait();
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0, 32'h200, 32'h55, 32'h0);
    cyc();
    bubble(); DM_Ready = 1'b0;
    cyc();
    #2;
    checks++; if (Mem_Stall !== 1'b1) begin failures++; $display("FAIL rst_pre_wait: got stall=%0b required 1", Mem_Stall); end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if ({DM_Req, DM_We, Mem_Stall} !== 3'b000) begin failures++; $display("FAIL rst_async: got req=%0b we=%0b stall=%0b required 0 0 0", DM_Req, DM_We, Mem_Stall); end
    checks++; if (Mem_Err !== 1'b0) begin failures++; $display("FAIL rst_err_clear: got %0b required 0", Mem_Err); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    checks++;
    if ({DM_Req, Mem_Stall, MEM_WB_Valid} !== 3'b000 || ALU_Result_1 !== 32'h0) begin
      failures++;
      $display("FAIL rst_after: got req=%0b stall=%0b wbv=%0b res=%h required all 0", DM_Req, Mem_Stall, MEM_WB_Valid, ALU_Result_1);
    end
    cyc();
    drive_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd11, 4'd0, 4'd0, 32'h300, 32'h0, 32'h3333);
    cyc();
    bubble(); DM_Ready = 1'b1; DM_RData = 32'h3333;
    @(negedge clk);
    checks++; if (DM_Req !== 1'b1 || DM_We !== 1'b0 || DM_Addr !== 32'h300) begin failures++; $display("FAIL rst_new_access: got req=%0b we=%0b addr=%h required 1 0 00000300", DM_Req, DM_We, DM_Addr); end
    cyc();
    DM_Ready = 1'b0; DM_RData = 32'h0;
    cyc(); cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forwarding();
    test_load_hit();
    test_store_wait();
    test_load_use();
    test_back_to_back();
    test_random_alu();
    test_timeout();
    test_reset_wait();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d writebacks outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
